mdio_phy_target: RTL and testbench

- PHY-side Clause 22 MDIO management responder, the target end of the MDC/MDIO master interface.
- Oversamples MDC/MDIO in the system clock domain and decodes preamble/ST/OP/PHYAD/REGAD/TA/DATA frames.
- Holds a 32x16 register file: updated on addressed writes, driven back onto MDIO on addressed reads.
- Used as a PHY model in simulation and as an on-FPGA loopback target for the management master.

---
 rtl/mdio_phy_target.sv | 232 +++++++++++++++++++++++
 tb/tb_mdio_phy_target.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_target.sv
// ============================================================================
// mdio_phy_target : Clause 22 MDIO management target with 32x16 register file
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mdio_phy_target #(
  parameter logic [4:0]  PHY_ADDR    = 5'd16,
  parameter int          PRE_MIN     = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] PHY_ID1     = 16'h0141,
  parameter logic [15:0] PHY_ID2     = 16'h0CC2
) (
  input  logic        i_sys_clk,
  input  logic        i_nreset,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdio_oe,
  output logic        o_wr_strobe,
  output logic [4:0]  o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic        o_frame_err,
  output logic        o_busy
);

  localparam int CW = $clog2(PRE_MIN + 1);
  localparam logic [CW-1:0] C_PRE_MAX = CW'(PRE_MIN);

  typedef enum logic [2:0] {
    S_PREAMBLE = 3'd0,
    S_ST       = 3'd1,
    S_OP       = 3'd2,
    S_PHYAD    = 3'd3,
    S_REGAD    = 3'd4,
    S_TA       = 3'd5,
    S_DATA     = 3'd6
  } state_t;

  logic [SYNC_STAGES-1:0] r_mdc_sync;
  logic [SYNC_STAGES-1:0] r_mdio_sync;
  logic                   r_mdc_prev;
  logic                   w_mdc;
  logic                   w_bit;
  logic                   w_rise;

  state_t         r_state;
  logic [CW-1:0]  r_pre_cnt;
  logic [3:0]     r_bit_cnt;
  logic           r_op0;
  logic           r_write;
  logic [4:0]     r_phyad;
  logic [4:0]     r_regad;
  logic           r_match;
  logic           r_ta_ok;
  logic [15:0]    r_shift;
  logic [15:0]    r_regs [32];

  logic           r_mdio;
  logic           r_mdio_oe;
  logic           r_wr_strobe;
  logic [4:0]     r_wr_addr;
  logic [15:0]    r_wr_data;
  logic           r_frame_err;
  logic           r_busy;

  assign w_mdc  = r_mdc_sync[SYNC_STAGES-1];
  assign w_bit  = r_mdio_sync[SYNC_STAGES-1];
  assign w_rise = w_mdc & ~r_mdc_prev;

  assign o_mdio      = r_mdio;
  assign o_mdio_oe   = r_mdio_oe;
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;

  always_ff @(posedge i_sys_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_mdc_sync  <= '0;
      r_mdio_sync <= '1;
      r_mdc_prev  <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], i_mdc};
      r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], i_mdio};
      r_mdc_prev  <= w_mdc;
    end
  end

  // Frame decoder; every state advance happens on exactly one MDC rise event.
  always_ff @(posedge i_sys_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state     <= S_PREAMBLE;
      r_pre_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_op0       <= 1'b0;
      r_write     <= 1'b0;
      r_phyad     <= '0;
      r_regad     <= '0;
      r_match     <= 1'b0;
      r_ta_ok     <= 1'b0;
      r_shift     <= '0;
      r_mdio      <= 1'b1;
      r_mdio_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      r_regs[2] <= PHY_ID1;
      r_regs[3] <= PHY_ID2;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_rise) begin
        case (r_state)
          S_PREAMBLE: begin
            if (w_bit) begin
              if (r_pre_cnt != C_PRE_MAX) r_pre_cnt <= r_pre_cnt + 1'b1;
            end else if (r_pre_cnt == C_PRE_MAX) begin
              r_state <= S_ST;
              r_busy  <= 1'b1;
            end else begin
              r_pre_cnt <= '0;
            end
          end
          S_ST: begin
            if (w_bit) begin
              r_state   <= S_OP;
              r_bit_cnt <= '0;
            end else begin
              r_state     <= S_PREAMBLE;
              r_pre_cnt   <= '0;
              r_busy      <= 1'b0;
              r_frame_err <= 1'b1;
            end
          end
          S_OP: begin
            r_op0 <= w_bit;
            if (r_bit_cnt == 4'd0) begin
              r_bit_cnt <= 4'd1;
            end else if (r_op0 != w_bit) begin
              r_write   <= w_bit;
              r_state   <= S_PHYAD;
              r_bit_cnt <= '0;
            end else begin
              r_state     <= S_PREAMBLE;
              r_pre_cnt   <= '0;
              r_busy      <= 1'b0;
              r_frame_err <= 1'b1;
            end
          end
          S_PHYAD: begin
            r_phyad <= {r_phyad[3:0], w_bit};
            if (r_bit_cnt == 4'd4) begin
              r_match   <= ({r_phyad[3:0], w_bit} == PHY_ADDR);
              r_state   <= S_REGAD;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_REGAD: begin
            r_regad <= {r_regad[3:0], w_bit};
            if (r_bit_cnt == 4'd4) begin
              r_state   <= S_TA;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          S_TA: begin
            if (r_bit_cnt == 4'd0) begin
              r_ta_ok   <= w_bit;
              r_bit_cnt <= 4'd1;
              if (!r_write && r_match) begin
                r_shift   <= r_regs[r_regad];
                r_mdio_oe <= 1'b1;
                r_mdio    <= 1'b0;
              end
            end else begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
              if (!r_write && r_match) begin
                r_mdio  <= r_shift[15];
                r_shift <= {r_shift[14:0], 1'b0};
              end
              if (r_write && !(r_ta_ok && !w_bit)) begin
                r_ta_ok     <= 1'b0;
                r_frame_err <= 1'b1;
              end
            end
          end
          S_DATA: begin
            if (r_write) begin
              r_shift <= {r_shift[14:0], w_bit};
            end else if (r_match) begin
              r_mdio  <= r_shift[15];
              r_shift <= {r_shift[14:0], 1'b0};
            end
            if (r_bit_cnt == 4'd15) begin
              r_state   <= S_PREAMBLE;
              r_pre_cnt <= '0;
              r_busy    <= 1'b0;
              r_mdio_oe <= 1'b0;
              r_mdio    <= 1'b1;
              // ID registers 2 and 3 are read-only; writes to them vanish.
              if (r_write && r_match && r_ta_ok && (r_regad[4:1] != 4'b0001)) begin
                r_regs[r_regad] <= {r_shift[14:0], w_bit};
                r_wr_strobe     <= 1'b1;
                r_wr_addr       <= r_regad;
                r_wr_data       <= {r_shift[14:0], w_bit};
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          default: begin
            r_state   <= S_PREAMBLE;
            r_pre_cnt <= '0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdio_phy_target.sv
// Directed bench for mdio_phy_target: bit-level MDC/MDIO master with pulse monitors.
`default_nettype none

module tb_mdio_phy_target;

  logic        clk = 1'b0;
  logic        nreset;
  logic        mdc;
  logic        mdio_drv;
  logic        pad;
  logic        o_mdio;
  logic        o_mdio_oe;
  logic        o_wr_strobe;
  logic [4:0]  o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_frame_err;
  logic        o_busy;

  int checks = 0;
  int passed = 0;
  int n_strobe = 0;
  int n_err = 0;
  int n_oe = 0;
  int n_busy = 0;

  always #5 clk = ~clk;

  assign pad = o_mdio_oe ? o_mdio : mdio_drv;

  mdio_phy_target dut (
    .i_sys_clk   (clk),
    .i_nreset    (nreset),
    .i_mdc       (mdc),
    .i_mdio      (pad),
    .o_mdio      (o_mdio),
    .o_mdio_oe   (o_mdio_oe),
    .o_wr_strobe (o_wr_strobe),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always @(posedge clk) begin
    if (o_wr_strobe) n_strobe++;
    if (o_frame_err) n_err++;
    if (o_mdio_oe)   n_oe++;
    if (o_busy)      n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One MDC period: master drives during low phase, samples pad just before the rise.
  task automatic send_bit(input logic b, output logic s);
    mdio_drv = b;
    repeat (8) @(negedge clk);
    s = pad;
    mdc = 1'b1;
    repeat (8) @(negedge clk);
    mdc = 1'b0;
  endtask

  // Preamble then the 32 frame bits; abort_k >= 0 stops mid-high-phase of that bit.
  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                           input int abort_k, output logic [31:0] samp);
    logic [31:0] seq;
    logic        s;
    seq  = {2'b01, op, pa, ra, ta, wd};
    samp = '0;
    for (int i = 0; i < pre; i++) send_bit(1'b1, s);
    for (int k = 0; k < 32; k++) begin
      if (k == abort_k) begin
        mdio_drv = seq[31-k];
        repeat (8) @(negedge clk);
        mdc = 1'b1;
        repeat (4) @(negedge clk);
        return;
      end
      send_bit(seq[31-k], s);
      samp[31-k] = s;
    end
    mdio_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_write(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [1:0] ta, input logic [15:0] wd);
    logic [31:0] samp;
    run_frame(pre, 2'b01, pa, ra, ta, wd, -1, samp);
  endtask

  task automatic do_read(input logic [4:0] ra, output logic [15:0] rd, output logic ta2);
    logic [31:0] samp;
    run_frame(32, 2'b10, 5'h10, ra, 2'b11, 16'hFFFF, -1, samp);
    rd  = samp[15:0];
    ta2 = samp[16];
  endtask

  initial begin
    logic [15:0] rd;
    logic        ta2;
    logic [31:0] samp;
    int          s0, e0, o0, b0;

    nreset = 1'b0;
    mdc = 1'b0;
    mdio_drv = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mdio", o_mdio, 1);
    check("rst_oe", o_mdio_oe, 0);
    check("rst_busy", o_busy, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    nreset = 1'b1;
    repeat (3) @(negedge clk);

    do_read(5'd2, rd, ta2);
    check("id1_data", rd, 16'h0141);
    check("id1_ta2", ta2, 0);
    do_read(5'd3, rd, ta2);
    check("id2_data", rd, 16'h0CC2);

    s0 = n_strobe; o0 = n_oe; b0 = n_busy;
    do_write(32, 5'h10, 5'd25, 2'b10, 16'hA5C3);
    check("wr25_strobe", n_strobe - s0, 1);
    check("wr25_addr", o_wr_addr, 25);
    check("wr25_data", o_wr_data, 16'hA5C3);
    check("wr25_no_oe", n_oe - o0, 0);
    check("wr25_busy_seen", (n_busy - b0) > 0, 1);
    check("wr25_busy_end", o_busy, 0);

    o0 = n_oe;
    do_read(5'd25, rd, ta2);
    check("rd25_data", rd, 16'hA5C3);
    check("rd25_ta2", ta2, 0);
    check("rd25_oe_seen", (n_oe - o0) > 0, 1);
    check("rd25_oe_end", o_mdio_oe, 0);
    check("rd25_mdio_end", o_mdio, 1);

    s0 = n_strobe;
    do_write(32, 5'h10, 5'd2, 2'b10, 16'hFFFF);
    check("wr_id_no_strobe", n_strobe - s0, 0);
    do_read(5'd2, rd, ta2);
    check("id1_after_wr", rd, 16'h0141);

    s0 = n_strobe; o0 = n_oe; b0 = n_busy;
    do_write(32, 5'h05, 5'd25, 2'b10, 16'h1234);
    check("phy5_no_strobe", n_strobe - s0, 0);
    check("phy5_no_oe", n_oe - o0, 0);
    check("phy5_busy_seen", (n_busy - b0) > 0, 1);
    check("phy5_busy_end", o_busy, 0);

    s0 = n_strobe; b0 = n_busy;
    do_write(31, 5'h10, 5'd25, 2'b10, 16'h1234);
    check("pre31_no_strobe", n_strobe - s0, 0);
    check("pre31_no_busy", n_busy - b0, 0);

    e0 = n_err;
    run_frame(32, 2'b11, 5'h10, 5'd25, 2'b10, 16'h1234, -1, samp);
    check("op11_err", n_err - e0, 1);
    check("op11_busy_end", o_busy, 0);

    e0 = n_err; s0 = n_strobe;
    do_write(32, 5'h10, 5'd25, 2'b11, 16'h1111);
    check("ta11_err", n_err - e0, 1);
    check("ta11_no_strobe", n_strobe - s0, 0);
    do_read(5'd25, rd, ta2);
    check("ta11_reg_kept", rd, 16'hA5C3);

    run_frame(32, 2'b10, 5'h10, 5'd25, 2'b11, 16'hFFFF, 24, samp);
    check("abort_oe_before", o_mdio_oe, 1);
    nreset = 1'b0;
    #1;
    check("abort_oe_async", o_mdio_oe, 0);
    check("abort_mdio_async", o_mdio, 1);
    repeat (2) @(negedge clk);
    mdc = 1'b0;
    mdio_drv = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    do_read(5'd25, rd, ta2);
    check("abort_reg25_cleared", rd, 16'h0000);
    do_read(5'd3, rd, ta2);
    check("abort_id2_restored", rd, 16'h0CC2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
